// File: rtl/count_seek_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_seek_ctrl
// Desc     : Steps a loadable counter toward a target using the L/EQ/G result
//            of an external combinational magnitude comparator, then raises
//            done for DONE_HOLD cycles. Optional watchdog: COUNT_SEEK_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module count_seek_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DONE_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] init_val,
    input  logic [WIDTH-1:0] target_val,
    input  logic             cmp_L,
    input  logic             cmp_EQ,
    input  logic             cmp_G,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] target,
    output logic             seed_great,
    output logic             seed_equal,
    output logic             seed_less,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(DONE_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   target_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               cmp_valid_d;
    logic               wd_expire_d;

    // The comparator result is trusted only when it is strictly one-hot.
    assign cmp_valid_d = ( cmp_L & ~cmp_EQ & ~cmp_G) |
                         (~cmp_L &  cmp_EQ & ~cmp_G) |
                         (~cmp_L & ~cmp_EQ &  cmp_G);

`ifdef COUNT_SEEK_TIMEOUT_EN
    localparam logic [WIDTH:0] WD_LIMIT = (WIDTH+1)'((1 << WIDTH) + 1);
    logic [WIDTH:0] wd_q;
    logic [WIDTH:0] wd_d;
    logic           timeout_q;

    assign wd_d        = wd_q + 1'b1;
    assign wd_expire_d = (wd_d == WD_LIMIT);
    assign timeout     = timeout_q;
`else
    assign wd_expire_d = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            target_q  <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef COUNT_SEEK_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_q  <= init_val;
                        target_q <= target_val;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
`ifdef COUNT_SEEK_TIMEOUT_EN
                        wd_q      <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
`ifdef COUNT_SEEK_TIMEOUT_EN
                    wd_q <= wd_d;
`endif
                    if (!cmp_valid_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cmp_EQ) begin
                        hold_q  <= HOLD_W'(DONE_HOLD);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (wd_expire_d) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef COUNT_SEEK_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end else if (cmp_L) begin
                        count_q <= count_q + 1'b1;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                S_DONE: begin
                    hold_q <= hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign count      = count_q;
    assign target     = target_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign seed_great = 1'b0;
    assign seed_equal = 1'b1;
    assign seed_less  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_count_seek_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_seek_ctrl
// Desc     : Randomized self-checking bench for count_seek_ctrl against a
//            closed-form timeline model of a seek.
// Revision : 1.0  initial release
// ============================================================================
module tb_count_seek_ctrl;

    localparam int WIDTH     = 4;
    localparam int DONE_HOLD = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] target_val;
    logic             cmp_L;
    logic             cmp_EQ;
    logic             cmp_G;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] target;
    logic             seed_great;
    logic             seed_equal;
    logic             seed_less;
    logic             busy;
    logic             done;
    logic             err;
    logic             timeout;

    logic             force_en;
    logic [2:0]       force_v;
    int               n_pass;
    int               n_checks;

    count_seek_ctrl #(
        .WIDTH     (WIDTH),
        .DONE_HOLD (DONE_HOLD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_val   (init_val),
        .target_val (target_val),
        .cmp_L      (cmp_L),
        .cmp_EQ     (cmp_EQ),
        .cmp_G      (cmp_G),
        .count      (count),
        .target     (target),
        .seed_great (seed_great),
        .seed_equal (seed_equal),
        .seed_less  (seed_less),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .timeout    (timeout)
    );

    // Behavioural stand-in for the downstream comparator, overridable for faults.
    assign cmp_L  = force_en ? force_v[2] : (count <  target);
    assign cmp_EQ = force_en ? force_v[1] : (count == target);
    assign cmp_G  = force_en ? force_v[0] : (count >  target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One seek checked cycle by cycle against its closed-form timeline:
    // i edges after acceptance, count has moved min(i,d) toward target,
    // done spans i in (d, d+DONE_HOLD], idle from i = d+DONE_HOLD+1.
    task automatic run_seek(input logic [WIDTH-1:0] ini, input logic [WIDTH-1:0] tgt,
                            input bit stray);
        int d;
        int last;
        int exp_cnt;
        d    = (ini > tgt) ? int'(ini) - int'(tgt) : int'(tgt) - int'(ini);
        last = d + DONE_HOLD + 1;
        start      = 1'b1;
        init_val   = ini;
        target_val = tgt;
        tick();
        start = 1'b0;
        for (int i = 0; i <= last; i++) begin
            if (i >= d)        exp_cnt = int'(tgt);
            else if (ini < tgt) exp_cnt = int'(ini) + i;
            else               exp_cnt = int'(ini) - i;
            check("count",   32'(count),   32'(exp_cnt[WIDTH-1:0]));
            check("target",  32'(target),  32'(tgt));
            check("busy",    32'(busy),    32'(i < last));
            check("done",    32'(done),    32'(i > d && i < last));
            check("err",     32'(err),     32'd0);
            check("timeout", 32'(timeout), 32'd0);
            if (i < last) begin
                if (stray) begin
                    start      = 1'($urandom_range(0, 1));
                    init_val   = WIDTH'($urandom);
                    target_val = WIDTH'($urandom);
                end
                tick();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        n_pass     = 0;
        n_checks   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        init_val   = '0;
        target_val = '0;
        force_en   = 1'b0;
        force_v    = 3'b000;
        repeat (2) tick();

        check("rst_count",   32'(count),      32'd0);
        check("rst_target",  32'(target),     32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_done",    32'(done),       32'd0);
        check("rst_err",     32'(err),        32'd0);
        check("rst_timeout", 32'(timeout),    32'd0);
        check("seed_g",      32'(seed_great), 32'd0);
        check("seed_e",      32'(seed_equal), 32'd1);
        check("seed_l",      32'(seed_less),  32'd0);
        rst = 1'b0;
        tick();

        run_seek(4'd3,  4'd7,  1'b0);
        run_seek(4'd15, 4'd0,  1'b0);
        run_seek(4'd5,  4'd5,  1'b0);
        run_seek(4'd1,  4'd2,  1'b1);
        run_seek(4'd0,  4'd15, 1'b1);

        // Reset asserted mid-run.
        start = 1'b1; init_val = 4'd2; target_val = 4'd9;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("mid_rst_count",  32'(count),  32'd0);
        check("mid_rst_target", 32'(target), 32'd0);
        check("mid_rst_busy",   32'(busy),   32'd0);
        check("mid_rst_done",   32'(done),   32'd0);
        check("mid_rst_err",    32'(err),    32'd0);
        tick();
        check("idle_hold_busy", 32'(busy),   32'd0);

        // Protocol errors: two-hot, then zero-hot.
        for (int k = 0; k < 2; k++) begin
            force_en = 1'b1;
            force_v  = (k == 0) ? 3'b101 : 3'b000;
            start = 1'b1; init_val = 4'd4; target_val = 4'd9;
            tick();
            start = 1'b0;
            check("perr_run_busy", 32'(busy),  32'd1);
            check("perr_run_cnt",  32'(count), 32'd4);
            tick();
            check("perr_err",    32'(err),    32'd1);
            check("perr_busy",   32'(busy),   32'd0);
            check("perr_count",  32'(count),  32'd4);
            check("perr_target", 32'(target), 32'd9);
            tick();
            check("perr_sticky", 32'(err),    32'd1);
            check("perr_held",   32'(count),  32'd4);
            force_en = 1'b0;
            run_seek(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        end

        // Runaway comparator: L stuck high with count == target.
        force_en = 1'b1;
        force_v  = 3'b100;
        start = 1'b1; init_val = 4'd0; target_val = 4'd0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
`ifdef COUNT_SEEK_TIMEOUT_EN
            check("wd_busy",    32'(busy),    32'(i < 17));
            check("wd_timeout", 32'(timeout), 32'(i >= 17));
`else
            check("wd_busy",    32'(busy),    32'd1);
            check("wd_timeout", 32'(timeout), 32'd0);
`endif
        end
        tick();
        check("wd_after", 32'(timeout),
`ifdef COUNT_SEEK_TIMEOUT_EN
              32'd1);
`else
              32'd0);
`endif
        force_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        for (int n = 0; n < 20; n++) begin
            run_seek(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
